// File: rtl/io_config_loader.sv
// io_config_loader
// Writer side of the IO block configuration path. Receives a byte-serial
// frame (sync, one config byte per IO block, XOR checksum) over a
// valid/ready port, validates it, then shifts {TSMUX[1:0], DORREG} per pad
// into the IO ring daisy chain and issues a single load strobe.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for SYNC_BYTE, other bytes are dropped
// RECV  | collecting NUM_IO config bytes into the store
// CHK   | waiting for the checksum byte
// SHIFT | 3*NUM_IO cycles of serial data out to the chain, CFG_SEN=1
// LOAD  | one-cycle CFG_LOAD strobe, then back to IDLE with DONE=1
module io_config_loader #(
  parameter int         NUM_IO    = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic       IOCLK,
  input  logic       RST,
  input  logic [7:0] WR_DATA,
  input  logic       WR_VALID,
  output logic       WR_READY,
  output logic       CFG_SDO,
  output logic       CFG_SEN,
  output logic       CFG_LOAD,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  localparam int IW = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
  localparam int BW = $clog2(3 * NUM_IO);
  localparam logic [IW-1:0] LAST_IO  = IW'(NUM_IO - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(3 * NUM_IO - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    CHK   = 3'd2,
    SHIFT = 3'd3,
    LOAD  = 3'd4
  } state_t;

  state_t        state;
  logic [IW-1:0] byte_cnt;
  logic [BW-1:0] bit_cnt;
  logic [IW-1:0] io_idx;
  logic [1:0]    bit_pos;
  logic [7:0]    csum;
  logic [2:0]    slot [NUM_IO];

  logic          accept;
  logic          rsvd_bad;
  logic [IW-1:0] nxt_io;
  logic [1:0]    nxt_pos;
  logic          nxt_bit;

  // Ready is a pure state decode, forced low while reset is held.
  assign WR_READY = ~RST & ((state == IDLE) | (state == RECV) | (state == CHK));
  assign BUSY     = (state != IDLE);
  assign accept   = WR_VALID & WR_READY;
  assign rsvd_bad = (WR_DATA[7:3] != 5'd0);

  // Next serial bit: walk TSMUX[1], TSMUX[0], DORREG within a pad, then step
  // down to the next lower pad. Index is clamped at 0 so it never leaves the store.
  always_comb begin
    nxt_io  = io_idx;
    nxt_pos = bit_pos + 2'd1;
    if (bit_pos == 2'd2) begin
      nxt_pos = 2'd0;
      if (io_idx != '0) nxt_io = io_idx - 1'b1;
    end
    nxt_bit = slot[nxt_io][2'd2 - nxt_pos];
  end

  // Config store: written only by clean RECV bytes; survives between frames.
  always_ff @(posedge IOCLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_IO; i++) slot[i] <= 3'd0;
    end else if ((state == RECV) && accept && !rsvd_bad) begin
      slot[byte_cnt] <= WR_DATA[2:0];
    end
  end

  // Frame sequencer with registered chain-side outputs and status flags.
  always_ff @(posedge IOCLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      byte_cnt <= '0;
      bit_cnt  <= '0;
      io_idx   <= '0;
      bit_pos  <= 2'd0;
      csum     <= 8'd0;
      CFG_SDO  <= 1'b0;
      CFG_SEN  <= 1'b0;
      CFG_LOAD <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && (WR_DATA == SYNC_BYTE)) begin
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            byte_cnt <= '0;
            csum     <= 8'd0;
            state    <= RECV;
          end
        end

        RECV: begin
          if (accept) begin
            if (rsvd_bad) begin
              ERR   <= 1'b1;
              state <= IDLE;
            end else begin
              csum <= csum ^ WR_DATA;
              if (byte_cnt == LAST_IO) begin
                state <= CHK;
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
              end
            end
          end
        end

        CHK: begin
          if (accept) begin
            if (WR_DATA == csum) begin
              // First bit is launched here so SHIFT starts with valid data.
              io_idx  <= LAST_IO;
              bit_pos <= 2'd0;
              bit_cnt <= '0;
              CFG_SDO <= slot[LAST_IO][2];
              CFG_SEN <= 1'b1;
              state   <= SHIFT;
            end else begin
              ERR   <= 1'b1;
              state <= IDLE;
            end
          end
        end

        SHIFT: begin
          if (bit_cnt == LAST_BIT) begin
            CFG_SEN  <= 1'b0;
            CFG_SDO  <= 1'b0;
            CFG_LOAD <= 1'b1;
            state    <= LOAD;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            io_idx  <= nxt_io;
            bit_pos <= nxt_pos;
            CFG_SDO <= nxt_bit;
          end
        end

        LOAD: begin
          CFG_LOAD <= 1'b0;
          DONE     <= 1'b1;
          state    <= IDLE;
        end

        default: begin
          CFG_SEN  <= 1'b0;
          CFG_LOAD <= 1'b0;
          CFG_SDO  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
